hz2period: RTL



---
 rtl/hz2period_pkg.sv | 12 +
 rtl/sig_sync_edge.sv | 45 ++++
 rtl/hz2period.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hz2period_pkg.sv
// Shared types and default sizing for the slow-signal period/duty meter.
package hz2period_pkg;

    localparam int unsigned DEF_CNT_W       = 24;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchroniser for an asynchronous level, followed by registered one-cycle rise/fall pulses.
module sig_sync_edge
    import hz2period_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the raw input through the synchroniser and compare the settled bit with its last value
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_sig};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    // State registers, cleared by the synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/hz2period.sv
// Measures period and high time of a slow asynchronous square wave in system-clock cycles.
module hz2period
    import hz2period_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = (32'd1 << CNT_W) - 32'd1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] r_high_q, r_high_d;
    logic             high_seen_q, high_seen_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] out_high_q, out_high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_sig),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    // Next-state: count between rises, capture high time on fall, publish on the following rise
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_high_d    = r_high_q;
        high_seen_d = high_seen_q;
        period_d    = period_q;
        out_high_d  = out_high_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d     = ST_MEASURE;
                    cnt_d       = CNT_ONE;
                    high_seen_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                cnt_d = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_ONE;
                if (rise) begin
                    // A rise on the timeout cycle still counts as a valid measurement
                    if (high_seen_q) begin
                        period_d   = cnt_q;
                        out_high_d = r_high_q;
                        valid_d    = 1'b1;
                        timeout_d  = 1'b0;
                    end
                    cnt_d       = CNT_ONE;
                    high_seen_d = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else if (fall) begin
                    r_high_d    = cnt_q;
                    high_seen_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        locked_d = (state_d == ST_MEASURE);
    end

    // State and output registers, cleared by the synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            r_high_q    <= '0;
            high_seen_q <= 1'b0;
            period_q    <= '0;
            out_high_q  <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_high_q    <= r_high_d;
            high_seen_q <= high_seen_d;
            period_q    <= period_d;
            out_high_q  <= out_high_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = out_high_q;
    assign o_valid   = valid_q;
    assign o_locked  = locked_q;
    assign o_timeout = timeout_q;

endmodule
